// File: rtl/alu_2_issue.sv
// Issue stage in front of the stateful ALU: decodes the action word, gathers operands and the
// tenant page-table entry, hands one action to alu_2 and forwards the PHV to the merge stage.
module alu_2_issue #(
  parameter int NUM_CONT   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ACTION_LEN = 64,
  parameter int TID_W      = 4,
  parameter int PHV_LEN    = NUM_CONT * DATA_WIDTH + TID_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PHV_LEN-1:0]    phv_in,
  input  logic [ACTION_LEN-1:0] act_in,
  input  logic                  phv_valid_in,
  output logic                  phv_ready_out,
  input  logic                  cfg_wr_en,
  input  logic [TID_W-1:0]      cfg_wr_addr,
  input  logic [15:0]           cfg_wr_data,
  output logic [ACTION_LEN-1:0] action_out,
  output logic                  action_valid,
  output logic [DATA_WIDTH-1:0] operand_1_out,
  output logic [DATA_WIDTH-1:0] operand_2_out,
  output logic [DATA_WIDTH-1:0] operand_3_out,
  input  logic                  alu_ready,
  output logic [15:0]           page_tbl_out,
  output logic                  page_tbl_out_valid,
  output logic [PHV_LEN-1:0]    phv_out,
  output logic [4:0]            dest_idx_out,
  output logic                  alu_issued_out,
  output logic                  phv_valid_out,
  input  logic                  phv_ready_in
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    ISSUE  = 3'd2,
    BUSY   = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic [PHV_LEN-1:0]    phv_reg;
  logic [ACTION_LEN-1:0] act_reg;
  logic [ACTION_LEN-1:0] action_reg;
  logic [DATA_WIDTH-1:0] operand_1_reg, operand_2_reg, operand_3_reg;
  logic [15:0]           page_reg;
  logic                  issued_reg;
  logic [15:0]           page_tbl [2**TID_W];

  // Container view spanning the full 5-bit index space; indices past NUM_CONT read as zero.
  logic [DATA_WIDTH-1:0] cont [32];

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_cont
      if (gi < NUM_CONT) begin : g_real
        assign cont[gi] = phv_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_zero
        assign cont[gi] = '0;
      end
    end
  endgenerate

  logic [3:0]            op;
  logic [4:0]            dest, src1, src2;
  logic [15:0]           imm;
  logic [TID_W-1:0]      tid;
  logic [DATA_WIDTH-1:0] operand_2_sel;

  assign op   = act_reg[24:21];
  assign dest = act_reg[29:25];
  assign src1 = act_reg[20:16];
  assign src2 = act_reg[15:11];
  assign imm  = act_reg[15:0];
  assign tid  = phv_reg[PHV_LEN-1 -: TID_W];

  // Only the two register-register ops take operand 2 from a container.
  assign operand_2_sel = (op == 4'b0001 || op == 4'b0010) ? cont[src2]
                                                          : {{(DATA_WIDTH-16){1'b0}}, imm};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (phv_valid_in) state_next = LOOKUP;
      LOOKUP:  state_next = (op == 4'b0000) ? OUT : ISSUE;
      ISSUE:   if (alu_ready) state_next = BUSY;
      BUSY:    if (alu_ready) state_next = OUT;
      OUT:     if (phv_ready_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    phv_ready_out  = 1'b0;
    action_valid   = 1'b0;
    phv_valid_out  = 1'b0;
    alu_issued_out = 1'b0;
    case (state_reg)
      IDLE:  phv_ready_out = 1'b1;
      ISSUE: action_valid  = alu_ready;
      OUT: begin
        phv_valid_out  = 1'b1;
        alu_issued_out = issued_reg;
      end
      default: ;
    endcase
  end

  assign page_tbl_out_valid = action_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phv_reg       <= '0;
      act_reg       <= '0;
      action_reg    <= '0;
      operand_1_reg <= '0;
      operand_2_reg <= '0;
      operand_3_reg <= '0;
      page_reg      <= '0;
      issued_reg    <= 1'b0;
    end else begin
      if (state_reg == IDLE && phv_valid_in) begin
        phv_reg <= phv_in;
        act_reg <= act_in;
      end
      // The table is sampled here, so a cfg write landing on this same edge is not seen.
      if (state_reg == LOOKUP) begin
        action_reg    <= act_reg;
        operand_1_reg <= cont[src1];
        operand_2_reg <= operand_2_sel;
        operand_3_reg <= cont[dest];
        page_reg      <= page_tbl[tid];
        issued_reg    <= (op != 4'b0000);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**TID_W; i++) begin
        page_tbl[i] <= '0;
      end
    end else if (cfg_wr_en) begin
      page_tbl[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  assign action_out    = action_reg;
  assign operand_1_out = operand_1_reg;
  assign operand_2_out = operand_2_reg;
  assign operand_3_out = operand_3_reg;
  assign page_tbl_out  = page_reg;
  assign phv_out       = phv_reg;
  assign dest_idx_out  = act_reg[29:25];

endmodule
